// File: rtl/pll_lock_monitor.sv
// Lock detector and frequency checker for the digital PLL, clocked by the reference osc.
// Waits for a stable trim word, then compares the windowed clockp edge count against div*WINDOW.
module pll_lock_monitor #(
    parameter int TRIM_W      = 26,
    parameter int DIV_W       = 5,
    parameter int CNT_W       = 8,
    parameter int STABLE_CYC  = 5,
    parameter int WINDOW      = 8,
    parameter int TOL_SHIFT   = 6,
    parameter int LOSS_WIN    = 2,
    parameter int TIMEOUT_CYC = 50,
    parameter int LT_W        = 16,
    localparam int ACC_W      = CNT_W + $clog2(WINDOW)
) (
    input  logic              osc,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div,
    input  logic [TRIM_W-1:0] trim,
    input  logic [CNT_W-1:0]  meas_cnt,
    input  logic              meas_valid,
    output logic              locked,
    output logic              timeout,
    output logic              lock_lost,
    output logic [LT_W-1:0]   lock_cycles,
    output logic [ACC_W-1:0]  freq_acc,
    output logic [2:0]        state
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_MEASURE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAIL    = 3'd4
    } state_t;

    localparam int SC_W   = $clog2(STABLE_CYC + 1);
    localparam int SMP_W  = $clog2(WINDOW);
    localparam int MISS_W = $clog2(LOSS_WIN + 1);
    localparam int CMP_W  = ACC_W + DIV_W + 2;

    localparam logic [SC_W-1:0]   STABLE_N = SC_W'(STABLE_CYC);
    localparam logic [SMP_W-1:0]  SMP_LAST = SMP_W'(WINDOW - 1);
    localparam logic [MISS_W-1:0] LOSS_N   = MISS_W'(LOSS_WIN);
    localparam logic [LT_W-1:0]   TMO_LC   = LT_W'(TIMEOUT_CYC);

    state_t              st;
    logic [TRIM_W-1:0]   trim_q;
    logic [DIV_W-1:0]    div_q;
    logic [SC_W-1:0]     stable_cnt;
    logic [SMP_W-1:0]    smp_cnt;
    logic [MISS_W-1:0]   miss_cnt;
    logic [ACC_W-1:0]    acc;

    logic [LT_W-1:0]     lc_inc;
    logic [SC_W-1:0]     sc_inc;
    logic [ACC_W-1:0]    sum;
    logic                win_done;
    logic                win_pass;
    logic                trim_chg;
    logic                restart;

    function automatic logic [LT_W-1:0] sat_inc(input logic [LT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // |sum - div*WINDOW| <= (div*WINDOW) >> TOL_SHIFT, evaluated with signed headroom
    function automatic logic in_band(input logic [ACC_W-1:0] s, input logic [DIV_W-1:0] d);
        logic signed [CMP_W-1:0] tgt;
        logic signed [CMP_W-1:0] tol;
        logic signed [CMP_W-1:0] diff;
        tgt  = $signed(CMP_W'(d)) <<< SMP_W;
        tol  = tgt >>> TOL_SHIFT;
        diff = $signed(CMP_W'(s)) - tgt;
        if (diff < 0) diff = -diff;
        return diff <= tol;
    endfunction

    assign lc_inc   = sat_inc(lock_cycles);
    assign sc_inc   = stable_cnt + 1'b1;
    assign sum      = acc + ACC_W'(meas_cnt);
    assign win_done = meas_valid && (smp_cnt == SMP_LAST);
    assign win_pass = in_band(sum, div_q);
    assign trim_chg = (trim != trim_q);
    assign restart  = (st != ST_IDLE) && (div != div_q);
    assign state    = st;

    always_ff @(posedge osc) begin
        if (reset) begin
            st          <= ST_IDLE;
            locked      <= 1'b0;
            timeout     <= 1'b0;
            lock_lost   <= 1'b0;
            lock_cycles <= '0;
            freq_acc    <= '0;
            stable_cnt  <= '0;
            smp_cnt     <= '0;
            miss_cnt    <= '0;
            acc         <= '0;
            trim_q      <= '0;
            div_q       <= '0;
        end else begin
            trim_q    <= trim;
            div_q     <= div;
            lock_lost <= 1'b0;
            // Disable, a new div target and the IDLE exit all start a fresh attempt
            if (!enable || restart || st == ST_IDLE) begin
                st          <= enable ? ST_ACQUIRE : ST_IDLE;
                locked      <= 1'b0;
                timeout     <= 1'b0;
                lock_cycles <= '0;
                stable_cnt  <= '0;
                smp_cnt     <= '0;
                miss_cnt    <= '0;
                acc         <= '0;
            end else begin
                case (st)
                    ST_ACQUIRE: begin
                        lock_cycles <= lc_inc;
                        if (lc_inc >= TMO_LC) begin
                            st      <= ST_FAIL;
                            timeout <= 1'b1;
                        end else if (trim_chg) begin
                            stable_cnt <= '0;
                        end else begin
                            stable_cnt <= sc_inc;
                            if (sc_inc == STABLE_N) begin
                                st      <= ST_MEASURE;
                                acc     <= '0;
                                smp_cnt <= '0;
                            end
                        end
                    end
                    ST_MEASURE: begin
                        lock_cycles <= lc_inc;
                        if (meas_valid) begin
                            acc     <= sum;
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                        if (win_done) freq_acc <= sum;
                        if (win_done && win_pass) begin
                            st       <= ST_LOCKED;
                            locked   <= 1'b1;
                            acc      <= '0;
                            miss_cnt <= '0;
                        end else if (lc_inc >= TMO_LC) begin
                            st      <= ST_FAIL;
                            timeout <= 1'b1;
                        end else if (win_done || trim_chg) begin
                            st         <= ST_ACQUIRE;
                            stable_cnt <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (meas_valid) begin
                            acc     <= sum;
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                        if (win_done) begin
                            freq_acc <= sum;
                            acc      <= '0;
                            if (win_pass) begin
                                miss_cnt <= '0;
                            end else if (miss_cnt + 1'b1 == LOSS_N) begin
                                st          <= ST_ACQUIRE;
                                locked      <= 1'b0;
                                lock_lost   <= 1'b1;
                                lock_cycles <= '0;
                                stable_cnt  <= '0;
                                miss_cnt    <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end
                    end
                    ST_FAIL: begin
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
